// File: rtl/gshare_dir_predictor_if.sv
// Fetch/EX-side signal bundle for the gshare direction predictor.
// master = pipeline/hazard side (drives lookups and resolved outcomes),
// slave  = predictor (returns prediction, history snapshot, mispredict flag).
interface gshare_dir_predictor_if #(
   parameter int PC_BITS = 14,
   parameter int GHR_LEN = 8,
   parameter int PERF_W  = 32
);
   // fetch-side lookup
   logic                branch_en_F;
   logic                stall_F;
   logic [PC_BITS-1:0]  PC_F;
   logic                BP_decision_F;
   logic [GHR_LEN-1:0]  ghr_F;

   // EX-side resolution
   logic                branch_en_EX;
   logic [PC_BITS-1:0]  PC_EX;
   logic [GHR_LEN-1:0]  ghr_EX;
   logic                BP_decision_EX;
   logic                branch_result;
   logic                mispredict_EX;

   // performance counters
   logic [PERF_W-1:0]   branch_cnt;
   logic [PERF_W-1:0]   mispredict_cnt;

   modport master (
      output branch_en_F, stall_F, PC_F,
      output branch_en_EX, PC_EX, ghr_EX, BP_decision_EX, branch_result,
      input  BP_decision_F, ghr_F, mispredict_EX, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  branch_en_F, stall_F, PC_F,
      input  branch_en_EX, PC_EX, ghr_EX, BP_decision_EX, branch_result,
      output BP_decision_F, ghr_F, mispredict_EX, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/gshare_dir_predictor.sv
// Parametrised gshare direction predictor: PHT of 2-bit counters indexed by PC^GHR,
// speculative global history with repair from EX. Lookup is combinational (0 cycles);
// updates land at the next clock. No backpressure: the hazard unit owns flush/redirect.
// Optional perf counters enabled with `define GSHARE_PERF_CNT_EN.
module gshare_dir_predictor #(
   parameter int PC_BITS  = 14,
   parameter int IDX_BITS = 8,
   parameter int GHR_LEN  = 8,
   parameter int PERF_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst,   // asynchronous, active-low
   gshare_dir_predictor_if.slave  bp
);

   localparam int PHT_DEPTH = 1 << IDX_BITS;

   // Flop-array pattern history table; reset-clearable so training can be discarded.
   logic [1:0]          pht_q [PHT_DEPTH];
   logic [1:0]          ctr_d;

   // Speculative global history, shifted at fetch and repaired on mispredict.
   logic [GHR_LEN-1:0]  ghr_q;
   logic [GHR_LEN-1:0]  ghr_d;

   logic [IDX_BITS-1:0] fetch_idx;
   logic [IDX_BITS-1:0] ex_idx;
   logic                pred_taken;
   logic                mispredict;

   // gshare index: word-aligned PC bits XOR history; PC alone supplies bits above GHR_LEN.
   function automatic logic [IDX_BITS-1:0] pht_idx(
      input logic [PC_BITS-1:0] pc,
      input logic [GHR_LEN-1:0] hist
   );
      logic [IDX_BITS-1:0] hist_ext;
      hist_ext               = '0;
      hist_ext[GHR_LEN-1:0]  = hist;
      return pc[IDX_BITS+1:2] ^ hist_ext;
   endfunction

   assign fetch_idx = pht_idx(bp.PC_F, ghr_q);
   assign ex_idx    = pht_idx(bp.PC_EX, bp.ghr_EX);

   // Lookup reads the registered table, so a same-cycle EX write is not bypassed.
   assign pred_taken        = bp.branch_en_F & pht_q[fetch_idx][1];
   assign bp.BP_decision_F  = pred_taken;
   assign bp.ghr_F          = ghr_q;

   assign mispredict        = bp.branch_en_EX & (bp.branch_result != bp.BP_decision_EX);
   assign bp.mispredict_EX  = mispredict;

   // Saturating 2-bit counter step for the entry being trained.
   always_comb begin
      ctr_d = pht_q[ex_idx];
      if (bp.branch_result) begin
         if (pht_q[ex_idx] != 2'b11) ctr_d = pht_q[ex_idx] + 2'b01;
      end else begin
         if (pht_q[ex_idx] != 2'b00) ctr_d = pht_q[ex_idx] - 2'b01;
      end
   end

   // PHT: all entries weakly not-taken on reset, train on every resolved EX branch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'b01;
      end else if (bp.branch_en_EX) begin
         pht_q[ex_idx] <= ctr_d;
      end
   end

   // History next-state: EX repair beats the fetch-side speculative shift.
   always_comb begin
      ghr_d = ghr_q;
      if (mispredict) begin
         ghr_d = {bp.ghr_EX[GHR_LEN-2:0], bp.branch_result};
      end else if (bp.branch_en_F && !bp.stall_F) begin
         ghr_d = {ghr_q[GHR_LEN-2:0], pred_taken};
      end
   end

   // Speculative history register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghr_q <= '0;
      else      ghr_q <= ghr_d;
   end

`ifdef GSHARE_PERF_CNT_EN
   logic [PERF_W-1:0] branch_cnt_q;
   logic [PERF_W-1:0] branch_cnt_d;
   logic [PERF_W-1:0] mispredict_cnt_q;
   logic [PERF_W-1:0] mispredict_cnt_d;

   // Counters saturate at all-ones so long runs never wrap back to small values.
   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (bp.branch_en_EX && (branch_cnt_q != {PERF_W{1'b1}}))
         branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispredict && (mispredict_cnt_q != {PERF_W{1'b1}}))
         mispredict_cnt_d = mispredict_cnt_q + 1'b1;
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign bp.branch_cnt     = branch_cnt_q;
   assign bp.mispredict_cnt = mispredict_cnt_q;
`else
   // Counters disabled: ports kept, driven to zero, no flops.
   assign bp.branch_cnt     = '0;
   assign bp.mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_gshare_dir_predictor.sv
// Self-checking bench for gshare_dir_predictor (PC_BITS=14, IDX_BITS=8, GHR_LEN=8, PERF_W=4).
// Reference model of PHT/GHR/counters feeds a scoreboard queue; directed checks add fixed values.
// Build with or without GSHARE_PERF_CNT_EN; counter expectations follow the macro.
module tb_gshare_dir_predictor;

   localparam int PC_BITS = 14;
   localparam int IDX_BITS = 8;
   localparam int GHR_LEN = 8;
   localparam int PERF_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   gshare_dir_predictor_if #(.PC_BITS(PC_BITS), .GHR_LEN(GHR_LEN), .PERF_W(PERF_W)) bif ();

   gshare_dir_predictor #(
      .PC_BITS(PC_BITS), .IDX_BITS(IDX_BITS), .GHR_LEN(GHR_LEN), .PERF_W(PERF_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bif)
   );

   typedef struct {
      logic       bp;
      logic [7:0] ghr;
      logic       mis;
      logic [3:0] bc;
      logic [3:0] mc;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [1:0] m_pht [256];
   logic [7:0] m_ghr;
   logic [3:0] m_bc;
   logic [3:0] m_mc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_idx(input logic [13:0] pc, input logic [7:0] h);
      return pc[9:2] ^ h;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
      m_ghr = 8'h00;
      m_bc  = 4'h0;
      m_mc  = 4'h0;
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_bp"},  {31'd0, bif.BP_decision_F}, {31'd0, e.bp});
      chk({tag, "_ghr"}, {24'd0, bif.ghr_F},         {24'd0, e.ghr});
      chk({tag, "_mis"}, {31'd0, bif.mispredict_EX}, {31'd0, e.mis});
      chk({tag, "_bc"},  {28'd0, bif.branch_cnt},    {28'd0, e.bc});
      chk({tag, "_mc"},  {28'd0, bif.mispredict_cnt},{28'd0, e.mc});
   endtask

   // One clock of stimulus, started at a negedge; ends at the following negedge.
   task automatic step(input string tag,
                       input logic bf, input logic st, input logic [13:0] pcf,
                       input logic be, input logic [13:0] pcex, input logic [7:0] gex,
                       input logic bpex, input logic res);
      exp_t e;
      logic [7:0] wi;
      bif.branch_en_F    = bf;
      bif.stall_F        = st;
      bif.PC_F           = pcf;
      bif.branch_en_EX   = be;
      bif.PC_EX          = pcex;
      bif.ghr_EX         = gex;
      bif.BP_decision_EX = bpex;
      bif.branch_result  = res;
      #1;
      e.bp  = bf & m_pht[m_idx(pcf, m_ghr)][1];
      e.ghr = m_ghr;
      e.mis = be & (res != bpex);
      e.bc  = m_bc;
      e.mc  = m_mc;
      sb_q.push_back(e);
      #1;
      check_out(tag);
      @(posedge clk);
      if (be) begin
         wi = m_idx(pcex, gex);
         if (res && m_pht[wi] != 2'b11) m_pht[wi] = m_pht[wi] + 2'b01;
         if (!res && m_pht[wi] != 2'b00) m_pht[wi] = m_pht[wi] - 2'b01;
      end
      if (e.mis)           m_ghr = {gex[6:0], res};
      else if (bf && !st)  m_ghr = {m_ghr[6:0], e.bp};
`ifdef GSHARE_PERF_CNT_EN
      if (be && m_bc != 4'hF)    m_bc = m_bc + 4'h1;
      if (e.mis && m_mc != 4'hF) m_mc = m_mc + 4'h1;
`endif
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      // reset state, with a mispredicting EX pattern to show mispredict_EX follows inputs
      rst = 1'b0;
      bif.branch_en_F = 1'b1; bif.stall_F = 1'b1; bif.PC_F = 14'h0100;
      bif.branch_en_EX = 1'b1; bif.PC_EX = 14'h0100; bif.ghr_EX = 8'h00;
      bif.BP_decision_EX = 1'b0; bif.branch_result = 1'b1;
      #3;
      chk("rst_bp",  {31'd0, bif.BP_decision_F}, 32'd0);
      chk("rst_ghr", {24'd0, bif.ghr_F}, 32'h00);
      chk("rst_mis", {31'd0, bif.mispredict_EX}, 32'd1);
      chk("rst_bc",  {28'd0, bif.branch_cnt}, 32'd0);
      chk("rst_mc",  {28'd0, bif.mispredict_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // training with fetch stalled; each mispredicting update repairs GHR to 0x01
      step("train1", 1, 1, 14'h0100, 1, 14'h0100, 8'h00, 0, 1);
      chk("train1_ghr", {24'd0, bif.ghr_F}, 32'h01);
      step("train2", 1, 1, 14'h0100, 1, 14'h0100, 8'h00, 0, 1);
      chk("train2_ghr", {24'd0, bif.ghr_F}, 32'h01);
      // return GHR to 0 via a mispredict on an unrelated entry
      step("ghr_clr", 0, 1, 14'h0100, 1, 14'h0200, 8'h00, 1, 0);
      chk("ghr_clr_ghr", {24'd0, bif.ghr_F}, 32'h00);
      step("lookup", 1, 1, 14'h0100, 0, 14'h0000, 8'h00, 0, 0);
      chk("trained_bp", {31'd0, bif.BP_decision_F}, 32'd1);

      // saturation: 11 -> 10 -> 01 -> 00 -> 00 -> 00
      for (int i = 0; i < 5; i++) begin
         step("sat", 1, 1, 14'h0100, 1, 14'h0100, 8'h00, 0, 0);
         chk("sat_bp", {31'd0, bif.BP_decision_F}, (i == 0) ? 32'd1 : 32'd0);
      end
      step("sat_up", 1, 1, 14'h0100, 1, 14'h0100, 8'h00, 1, 1);
      chk("sat_up_bp", {31'd0, bif.BP_decision_F}, 32'd0);

      // retrain to 11, then speculative shift with and without stall
      step("retrain", 1, 1, 14'h0100, 1, 14'h0100, 8'h00, 1, 1);
      step("retrain", 1, 1, 14'h0100, 1, 14'h0100, 8'h00, 1, 1);
      chk("retrain_bp", {31'd0, bif.BP_decision_F}, 32'd1);
      step("shift", 1, 0, 14'h0100, 0, 14'h0000, 8'h00, 0, 0);
      chk("shift_ghr", {24'd0, bif.ghr_F}, 32'h01);
      step("hold", 1, 1, 14'h0100, 0, 14'h0000, 8'h00, 0, 0);
      chk("hold_ghr", {24'd0, bif.ghr_F}, 32'h01);

      // repair beats fetch shift in the same cycle
      step("repair", 1, 0, 14'h0100, 1, 14'h0300, 8'h05, 0, 1);
      chk("repair_ghr", {24'd0, bif.ghr_F}, 32'h0B);

      // same-index read/write: lookup sees old 01, next cycle sees 10
      step("nobypass", 1, 1, 14'h0100, 1, 14'h0100, 8'h0B, 1, 1);
      chk("nobypass_next_bp", {31'd0, bif.BP_decision_F}, 32'd1);

      // asynchronous reset mid-cycle discards training (entry at GHR=0 was 11)
      bif.branch_en_F = 1'b1; bif.stall_F = 1'b1; bif.PC_F = 14'h0100;
      bif.branch_en_EX = 1'b0;
      #1 rst = 1'b0;
      #1;
      model_reset();
      chk("midrst_bp",  {31'd0, bif.BP_decision_F}, 32'd0);
      chk("midrst_ghr", {24'd0, bif.ghr_F}, 32'h00);
      chk("midrst_bc",  {28'd0, bif.branch_cnt}, 32'd0);
      chk("midrst_mc",  {28'd0, bif.mispredict_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // perf counters: 20 EX branches, 3 of them mispredicted
      for (int i = 0; i < 20; i++) begin
         logic mp;
         mp = (i == 3) || (i == 9) || (i == 15);
         step("perf", 0, 1, 14'h0000, 1, 14'(i << 2), 8'h00, 0, mp);
      end
`ifdef GSHARE_PERF_CNT_EN
      chk("perf_bc", {28'd0, bif.branch_cnt}, 32'hF);
      chk("perf_mc", {28'd0, bif.mispredict_cnt}, 32'd3);
`else
      chk("perf_bc", {28'd0, bif.branch_cnt}, 32'd0);
      chk("perf_mc", {28'd0, bif.mispredict_cnt}, 32'd0);
`endif

      // random traffic against the model; PCs confined to a small set to force aliasing
      for (int i = 0; i < 300; i++) begin
         logic [13:0] pf, pe;
         pf = 14'($urandom_range(0, 15) << 2);
         pe = 14'($urandom_range(0, 15) << 2);
         step("rand", 1'($urandom), 1'($urandom), pf,
              1'($urandom), pe, 8'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
